text_console_writer: RTL
========================

// Module: text_console_writer
// PURPOSE
//  Byte-stream terminal front end for the text-mode LCD display. Accepts ASCII bytes from the MCU
//  over a valid/ready handshake, keeps a cursor, interprets control codes, and writes {attr,char}
//  cells into the VRAM write port (port A) that the display pipeline reads. VRAM port A is
//  write-only, so scrolling is done by wrap-to-top plus clearing the newly entered row.
// PARAMETERS
//  ADDR_W     12   VRAM write address width
//  CPL_LAND   50   chars per line, direction 0/2 (800/8/2)
//  ROWS_LAND  15   rows, direction 0/2 (480/16/2)
//  CPL_PORT   30   chars per line, direction 1/3 (480/8/2)
//  ROWS_PORT  25   rows, direction 1/3 (800/16/2)
// PORTS
//  clk         in   1   write clock; same clock as VRAM port A (ram_clk)
//  reset       in   1   synchronous, active-high
//  direction   in   2   display rotation; selects geometry; sampled only in IDLE
//  attr        in   8   {bg[3:0],fg[3:0]}; sampled when a byte is accepted or a clear starts
//  in_valid    in   1   byte available
//  in_data     in   8   ASCII byte
//  in_ready    out  1   block can accept a byte this cycle
//  busy        out  1   clear operation in progress
//  cursor_col  out  6   current column
//  cursor_row  out  5   current row
//  ram_ce      out  1   VRAM write strobe, one cell per cycle
//  ram_addr    out  12  cell address = row*cpl + col
//  ram_data    out  16  {attr, 1'b0, char[6:0]}
// BEHAVIOUR
//  Reset: ram_ce=0, ram_addr=0, ram_data=0, cursor=(0,0), in_ready=0, busy=1, state=CLR_SCR,
//   latched attr=8'h00. Clearing starts the cycle after reset deasserts.
//  States: IDLE, PUT, CLR_ROW, CLR_SCR.
//  IDLE: in_ready=1, busy=0. Accept on in_valid&&in_ready; latch in_data, attr, geometry.
//   0x20-0x7E: -> PUT. Next cycle ram_ce=1, addr=cursor address, data={attr,char}; col+1.
//     If col reaches cpl: col=0, advance row (see newline) and -> CLR_ROW, else -> IDLE.
//   0x0D CR: col=0, stay IDLE, no write.
//   0x0A LF: col=0, advance row, -> CLR_ROW.
//   0x08 BS: col>0: col-1, PUT writes {attr,0x20} at the new col, cursor stays there.
//     col==0: no-op, no write.
//   0x0C FF: -> CLR_SCR; cursor (0,0) on completion.
//   All other bytes: consumed, no write, no cursor change.
//  Newline: row+1; row==rows-1 wraps to 0. No hardware scroll.
//  CLR_ROW: cpl consecutive writes of {attr,0x20}, addresses row_base .. row_base+cpl-1, one per
//   cycle; -> IDLE after the last write.
//  CLR_SCR: cpl*rows (750 in both geometries) writes from address 0 upward; -> IDLE.
//  in_ready=0 in every state except IDLE, so at most one byte per 2 cycles for printables.
//  Write latency: ram_ce is asserted exactly 1 cycle after byte acceptance. ram_ce is 0 in
//   every cycle that does not write.
//  Address: row_base register, updated by +cpl on newline and set to 0 on wrap. No multiplier.
//  Width: cursor_col < cpl <= 50, row < 25, max address 749, upper address bits always 0.
//  direction change while busy: ignored until IDLE. A change in IDLE resets the cursor to (0,0)
//   and starts CLR_SCR, because the old geometry is invalid.
//  Reset mid-clear: aborts immediately and restarts CLR_SCR from address 0.
//  in_data must be held stable while in_valid=1 && in_ready=0 (standard valid/ready).
// STRUCTURE
//  Shared package (lcd_pkg): geometry constants, char codes CH_BS/LF/CR/FF/SPACE,
//   state enum, attr field layout.
//  One sub-module: vram_fill_counter. Start, base, length in; it emits addr and ce each cycle
//   and asserts done. It is shared by CLR_ROW and CLR_SCR.
// TESTING
//  Reset, then count writes: exactly 750 writes of 0x0020 at addresses 0..749; busy then 0;
//   in_ready then 1.
//  attr=8'h1F, dir=0, send 'A' (0x41): one write, addr 0, data 16'h1F41, one cycle after
//   accept; cursor (1,0).
//  Send 50 printables: the 50th lands at addr 49; then 50 clear writes at 50..99; cursor (0,1).
//  Cursor at row 14, send LF (dir 0): row wraps to 0; clear writes at addr 0..49.
//  At col 0 send BS: no write. At col 3 send BS: write 0x0020-with-attr at col 2; cursor col 2.
//  In IDLE, change direction 0->1: 750 clears, cursor (0,0); then 31 printables give a write
//   at addr 30 (row 1) after row 1 is cleared.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared definitions for the text-mode LCD front end: geometry defaults, control codes,
// FSM states, attribute layout and the cell-packing helpers.
package lcd_pkg;

    localparam int ADDR_W_DEF    = 12;
    localparam int CPL_LAND_DEF  = 50;
    localparam int ROWS_LAND_DEF = 15;
    localparam int CPL_PORT_DEF  = 30;
    localparam int ROWS_PORT_DEF = 25;

    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_TILDE = 8'h7E;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PUT     = 2'd1,
        ST_CLR_ROW = 2'd2,
        ST_CLR_SCR = 2'd3
    } state_t;

    typedef struct packed {
        logic [3:0] bg;
        logic [3:0] fg;
    } attr_t;

    function automatic logic [15:0] make_cell(input attr_t a, input logic [6:0] ch);
        return {a, 1'b0, ch};
    endfunction

    function automatic logic is_printable(input logic [7:0] ch);
        return (ch >= CH_SPACE) && (ch <= CH_TILDE);
    endfunction

endpackage

// File: rtl/vram_fill_counter.sv
// Sequential address generator for block clears: emits one write strobe per cycle from
// base for len cells, with the first strobe in the start cycle itself.
module vram_fill_counter #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] len,
    output logic [ADDR_W-1:0] addr,
    output logic              ce,
    output logic              done
);

    logic              active_r;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] left_r;

    // Current strobe/address; the start cycle writes base directly so no cycle is lost.
    always_comb begin
        ce   = 1'b0;
        addr = addr_r;
        done = 1'b0;
        if (start) begin
            ce   = 1'b1;
            addr = base;
            done = (len == ADDR_W'(1));
        end else if (active_r) begin
            ce   = 1'b1;
            addr = addr_r;
            done = (left_r == ADDR_W'(1));
        end else begin
            ce   = 1'b0;
            addr = addr_r;
            done = 1'b0;
        end
    end

    // Remaining-count and address state.
    always_ff @(posedge clk) begin
        if (reset) begin
            active_r <= 1'b0;
            addr_r   <= '0;
            left_r   <= '0;
        end else if (start) begin
            addr_r   <= base + ADDR_W'(1);
            left_r   <= len - ADDR_W'(1);
            active_r <= (len > ADDR_W'(1));
        end else if (active_r) begin
            addr_r <= addr_r + ADDR_W'(1);
            left_r <= left_r - ADDR_W'(1);
            if (left_r == ADDR_W'(1)) begin
                active_r <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/text_console_writer.sv
// Byte-stream terminal front end: accepts ASCII over valid/ready, tracks the cursor,
// interprets control codes and writes {attr,char} cells into VRAM port A.
module text_console_writer
    import lcd_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int CPL_LAND  = CPL_LAND_DEF,
    parameter int ROWS_LAND = ROWS_LAND_DEF,
    parameter int CPL_PORT  = CPL_PORT_DEF,
    parameter int ROWS_PORT = ROWS_PORT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        direction,
    input  logic [7:0]        attr,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              busy,
    output logic [5:0]        cursor_col,
    output logic [4:0]        cursor_row,
    output logic              ram_ce,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [15:0]       ram_data
);

    localparam logic [5:0]        CPL_L = 6'(CPL_LAND);
    localparam logic [4:0]        ROWS_L = 5'(ROWS_LAND);
    localparam logic [ADDR_W-1:0] SCR_L = ADDR_W'(CPL_LAND * ROWS_LAND);
    localparam logic [5:0]        CPL_P = 6'(CPL_PORT);
    localparam logic [4:0]        ROWS_P = 5'(ROWS_PORT);
    localparam logic [ADDR_W-1:0] SCR_P = ADDR_W'(CPL_PORT * ROWS_PORT);

    state_t            state_r;
    state_t            state_nx_s;
    logic [1:0]        dir_r;
    attr_t             attr_r;
    logic [5:0]        col_r;
    logic [4:0]        row_r;
    logic [ADDR_W-1:0] row_base_r;
    logic              wrap_pend_r;
    logic              start_pend_r;

    logic [5:0]        cpl_s;
    logic [4:0]        rows_s;
    logic [ADDR_W-1:0] scr_len_s;
    logic [ADDR_W-1:0] cpl_ext_s;
    logic [ADDR_W-1:0] cur_addr_s;
    logic              row_last_s;
    logic [4:0]        row_adv_s;
    logic [ADDR_W-1:0] base_adv_s;

    logic              dir_chg_s;
    logic              in_ready_s;
    logic              accept_s;
    logic              is_print_s;

    logic              fill_start_s;
    logic [ADDR_W-1:0] fill_base_s;
    logic [ADDR_W-1:0] fill_len_s;
    logic [ADDR_W-1:0] fill_addr_s;
    logic              fill_ce_s;
    logic              fill_done_s;

    logic              wr_ce_s;
    logic [ADDR_W-1:0] wr_addr_s;
    logic [15:0]       wr_data_s;

    // Geometry follows the direction latched in IDLE, never the live input.
    always_comb begin
        cpl_s     = CPL_L;
        rows_s    = ROWS_L;
        scr_len_s = SCR_L;
        if (dir_r[0]) begin
            cpl_s     = CPL_P;
            rows_s    = ROWS_P;
            scr_len_s = SCR_P;
        end else begin
            cpl_s     = CPL_L;
            rows_s    = ROWS_L;
            scr_len_s = SCR_L;
        end
    end

    assign cpl_ext_s  = {{(ADDR_W-6){1'b0}}, cpl_s};
    assign cur_addr_s = row_base_r + {{(ADDR_W-6){1'b0}}, col_r};

    // Newline target: row_base tracks row*cpl incrementally and wraps to 0 with the row.
    always_comb begin
        row_last_s = (row_r == (rows_s - 5'd1));
        row_adv_s  = row_r + 5'd1;
        base_adv_s = row_base_r + cpl_ext_s;
        if (row_last_s) begin
            row_adv_s  = 5'd0;
            base_adv_s = '0;
        end else begin
            row_adv_s  = row_r + 5'd1;
            base_adv_s = row_base_r + cpl_ext_s;
        end
    end

    assign dir_chg_s  = (direction != dir_r);
    assign in_ready_s = (state_r == ST_IDLE) && !dir_chg_s;
    assign accept_s   = in_valid && in_ready_s;
    assign is_print_s = is_printable(in_data);

    // Next state and the single VRAM write of this cycle (byte write or fill cell).
    always_comb begin
        state_nx_s   = state_r;
        wr_ce_s      = 1'b0;
        wr_addr_s    = '0;
        wr_data_s    = 16'h0000;
        fill_start_s = 1'b0;
        fill_base_s  = row_base_r;
        fill_len_s   = cpl_ext_s;
        case (state_r)
            ST_IDLE: begin
                if (dir_chg_s) begin
                    state_nx_s = ST_CLR_SCR;
                end else if (accept_s) begin
                    if (is_print_s) begin
                        state_nx_s = ST_PUT;
                        wr_ce_s    = 1'b1;
                        wr_addr_s  = cur_addr_s;
                        wr_data_s  = make_cell(attr_t'(attr), in_data[6:0]);
                    end else if ((in_data == CH_BS) && (col_r != 6'd0)) begin
                        state_nx_s = ST_PUT;
                        wr_ce_s    = 1'b1;
                        wr_addr_s  = cur_addr_s - ADDR_W'(1);
                        wr_data_s  = make_cell(attr_t'(attr), CH_SPACE[6:0]);
                    end else if (in_data == CH_LF) begin
                        state_nx_s = ST_CLR_ROW;
                    end else if (in_data == CH_FF) begin
                        state_nx_s = ST_CLR_SCR;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_PUT: begin
                if (wrap_pend_r) begin
                    state_nx_s = ST_CLR_ROW;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_CLR_ROW, ST_CLR_SCR: begin
                fill_start_s = start_pend_r;
                if (state_r == ST_CLR_SCR) begin
                    fill_base_s = '0;
                    fill_len_s  = scr_len_s;
                end else begin
                    fill_base_s = row_base_r;
                    fill_len_s  = cpl_ext_s;
                end
                if (fill_ce_s) begin
                    wr_ce_s   = 1'b1;
                    wr_addr_s = fill_addr_s;
                    wr_data_s = make_cell(attr_r, CH_SPACE[6:0]);
                end else begin
                    wr_ce_s = 1'b0;
                end
                if (fill_done_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = state_r;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    vram_fill_counter #(
        .ADDR_W (ADDR_W)
    ) u_fill (
        .clk   (clk),
        .reset (reset),
        .start (fill_start_s),
        .base  (fill_base_s),
        .len   (fill_len_s),
        .addr  (fill_addr_s),
        .ce    (fill_ce_s),
        .done  (fill_done_s)
    );

    // State register; reset always lands in a full-screen clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_CLR_SCR;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Cursor, latched attribute/geometry and fill kick-off.
    always_ff @(posedge clk) begin
        if (reset) begin
            dir_r        <= direction;
            attr_r       <= attr_t'(8'h00);
            col_r        <= 6'd0;
            row_r        <= 5'd0;
            row_base_r   <= '0;
            wrap_pend_r  <= 1'b0;
            start_pend_r <= 1'b1;
        end else begin
            start_pend_r <= (state_nx_s != state_r) &&
                            ((state_nx_s == ST_CLR_ROW) || (state_nx_s == ST_CLR_SCR));
            case (state_r)
                ST_IDLE: begin
                    if (dir_chg_s) begin
                        dir_r      <= direction;
                        attr_r     <= attr_t'(attr);
                        col_r      <= 6'd0;
                        row_r      <= 5'd0;
                        row_base_r <= '0;
                    end else if (accept_s) begin
                        attr_r      <= attr_t'(attr);
                        wrap_pend_r <= 1'b0;
                        if (is_print_s) begin
                            if (col_r == (cpl_s - 6'd1)) begin
                                col_r       <= 6'd0;
                                row_r       <= row_adv_s;
                                row_base_r  <= base_adv_s;
                                wrap_pend_r <= 1'b1;
                            end else begin
                                col_r <= col_r + 6'd1;
                            end
                        end else if ((in_data == CH_BS) && (col_r != 6'd0)) begin
                            col_r <= col_r - 6'd1;
                        end else if (in_data == CH_CR) begin
                            col_r <= 6'd0;
                        end else if (in_data == CH_LF) begin
                            col_r      <= 6'd0;
                            row_r      <= row_adv_s;
                            row_base_r <= base_adv_s;
                        end
                    end
                end
                ST_CLR_SCR: begin
                    if (fill_done_s) begin
                        col_r      <= 6'd0;
                        row_r      <= 5'd0;
                        row_base_r <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Registered VRAM port; address/data hold between writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            ram_ce   <= 1'b0;
            ram_addr <= '0;
            ram_data <= 16'h0000;
        end else begin
            ram_ce <= wr_ce_s;
            if (wr_ce_s) begin
                ram_addr <= wr_addr_s;
                ram_data <= wr_data_s;
            end
        end
    end

    assign in_ready   = in_ready_s;
    assign busy       = (state_r == ST_CLR_ROW) || (state_r == ST_CLR_SCR);
    assign cursor_col = col_r;
    assign cursor_row = row_r;

endmodule
